spi_share_arb: RTL and testbench
================================

Name: spi_share_arb

Overview:
- Arbitrates one shared SPI_mnrch between two requesters: req0 is the inertial interface, req1 is a second SPI peripheral such as the A2D.
- Serializes 16-bit transactions, routes the done strobe back to the owning requester and demuxes SS_n to the correct slave.
- Round-robin fairness; an enforced idle gap between transactions meets slave CS-high time.
- Sits between the requesters and the single SPI_mnrch instance.

Parameters:
- GAP_CYC, 8: clocks SS_n is held idle after a done before the next grant (1..255).
- TMO_CYC, 4095: clocks to wait for spi_done before aborting. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 wants a transaction; hold high with cmd0 stable until done0
- cmd0  in  16  requester 0 SPI command
- req1  in  1  requester 1 request
- cmd1  in  16  requester 1 SPI command
- done0  out  1  1-clk pulse, requester 0 transaction complete
- done1  out  1  1-clk pulse, requester 1 transaction complete
- rd_data  out  16  spi_rd_data passed through combinationally; valid when doneN pulses
- spi_wrt  out  1  1-clk start strobe to SPI_mnrch
- spi_cmd  out  16  wrt_data to SPI_mnrch, registered
- spi_done  in  1  done from SPI_mnrch
- spi_rd_data  in  16  rd_data from SPI_mnrch
- spi_SS_n  in  1  SS_n from SPI_mnrch
- SS0_n  out  1  slave select to device 0
- SS1_n  out  1  slave select to device 1
- err  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Reset values:
  - state=IDLE, owner=0, last=1 (so req0 wins the first tie).
  - spi_wrt=0, spi_cmd=16'h0000, done0=done1=0, err=0, gap counter=0.
  - SS0_n=SS1_n=1.
- IDLE:
  - Evaluate the requests: if only one is high, grant it. If both are high, grant the one that is not `last`.
  - On grant: register owner, load spi_cmd from cmdN, pulse spi_wrt for one clock and go to BUSY.
  - The spi_wrt pulse lands in the clock following the cycle in which the request is sampled.
- BUSY:
  - Wait for spi_done.
  - On spi_done=1: pulse doneN for the owner in that same cycle (combinational off spi_done and owner). Set last=owner, clear the gap counter and go to GAP.
  - spi_wrt stays 0 throughout BUSY.
- GAP:
  - Count GAP_CYC clocks, then return to IDLE. Requests are not evaluated during GAP.
  - A requester that raises its request again right after doneN is served after GAP.
- SS demux:
  - SSN_n = spi_SS_n when state is BUSY and owner==N, otherwise 1.
  - The non-owner select never toggles.
- Request-drop rules:
  - reqN dropping during BUSY does not abort: the transaction completes and doneN still pulses.
  - reqN dropping in IDLE before grant means no transaction.
- Data and arithmetic:
  - spi_cmd is held constant through BUSY even if cmdN changes.
  - Gap counter is 8 bits, saturating; no wrap concerns.
- Boundary cases:
  - spi_done outside BUSY is ignored; neither done pulses.
  - Reset asserted mid-BUSY: all outputs return to reset values immediately (async). SPI_mnrch is reset by the same rst_n.
- Fairness and latency:
  - Worst-case wait for a continuously requesting master is one peer transaction plus GAP_CYC plus 2 clocks.

Optional Feature:
- Macro: SPI_SHARE_ARB_TMO_EN.
- Defined:
  - A 12-bit counter runs in BUSY. If it reaches TMO_CYC with no spi_done, set err (sticky until reset).
  - Pulse doneN for the owner with rd_data forced to 16'hFFFF for that cycle, set last=owner and go to GAP.
  - A late spi_done arriving after the abort is ignored.
- Undefined: no counter; BUSY waits indefinitely; err=0.

Test Plan:
- req0 alone, cmd0=16'hA200:
  - spi_wrt pulses once, 1 clk after req0 is sampled, with spi_cmd=16'hA200.
  - SS0_n follows spi_SS_n; SS1_n stays 1.
  - spi_rd_data=16'h00C5 → done0 pulse with rd_data=16'h00C5.
- req0 and req1 both high continuously, cmd0=16'h0D02, cmd1=16'h2000:
  - Grants alternate 0,1,0,1.
  - Each spi_wrt is separated from the prior spi_done by ≥GAP_CYC+1 clocks.
- req1 held for a long burst, then req0 raised mid-transaction:
  - The req1 transaction completes first.
  - The next grant goes to req0.
- cmd0 changed from 16'hA300 to 16'h1111 during BUSY:
  - spi_cmd stays 16'hA300.
  - Exactly one done0 pulse.
- rst_n dropped mid-BUSY:
  - SS0_n=SS1_n=1, spi_wrt=0 and done0=done1=0 asynchronously.
  - After release, the first grant goes to req0.
- With SPI_SHARE_ARB_TMO_EN, spi_done held low:
  - After TMO_CYC clocks: err=1, done0 pulse with rd_data=16'hFFFF.
  - A subsequent req1 is still serviced normally.

Source files
------------

// File: rtl/spi_share_arb.sv
// Round-robin arbiter sharing one SPI master between two requesters, with an idle gap between transactions.
// Optional BUSY timeout abort is enabled by defining SPI_SHARE_ARB_TMO_EN.
module spi_share_arb #(
  parameter int GAP_CYC = 8,
  parameter int TMO_CYC = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  input  logic        spi_SS_n,
  output logic        SS0_n,
  output logic        SS1_n,
  output logic        err
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  if (GAP_CYC < 1 || GAP_CYC > 255) begin : g_bad_gap
    $error("spi_share_arb: GAP_CYC out of range 1..255");
  end
  if (TMO_CYC < 1 || TMO_CYC > 4095) begin : g_bad_tmo
    $error("spi_share_arb: TMO_CYC out of range 1..4095");
  end

  state_t      r_state;
  state_t      w_nxt_state;
  logic        r_owner;
  logic        r_last;
  logic [7:0]  r_gap_cnt;
  logic        r_wrt;
  logic [15:0] r_cmd;
  logic        w_grant;
  logic        w_grant_own;
  logic        w_finish;
  logic        w_abort;

`ifdef SPI_SHARE_ARB_TMO_EN
  localparam logic [11:0] TMO_LAST = 12'(TMO_CYC - 1);
  logic [11:0] r_tmo_cnt;
  logic        r_err;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_grant     = 1'b0;
    w_grant_own = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_grant     = 1'b1;
          // On a tie the requester that did not go last wins.
          w_grant_own = (req0 && req1) ? ~r_last : req1;
          w_nxt_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (spi_done) begin
          w_finish = 1'b1;
        end
`ifdef SPI_SHARE_ARB_TMO_EN
        else if (r_tmo_cnt == TMO_LAST) begin
          w_finish = 1'b1;
          w_abort  = 1'b1;
        end
`endif
        if (w_finish) w_nxt_state = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap_cnt >= GAP_LAST) w_nxt_state = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_gap_cnt <= 8'd0;
      r_wrt     <= 1'b0;
      r_cmd     <= 16'h0000;
    end else begin
      r_state <= w_nxt_state;
      r_wrt   <= w_grant;
      if (w_grant) begin
        r_owner <= w_grant_own;
        r_cmd   <= w_grant_own ? cmd1 : cmd0;
      end
      if (w_finish) begin
        r_last    <= r_owner;
        r_gap_cnt <= 8'd0;
      end else if (r_state == ST_GAP && r_gap_cnt != 8'hFF) begin
        r_gap_cnt <= r_gap_cnt + 8'd1;
      end
    end
  end

`ifdef SPI_SHARE_ARB_TMO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= 12'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_tmo_cnt <= 12'd0;
      end else if (r_state == ST_BUSY && r_tmo_cnt != 12'hFFF) begin
        r_tmo_cnt <= r_tmo_cnt + 12'd1;
      end
      if (w_abort) r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign spi_wrt = r_wrt;
  assign spi_cmd = r_cmd;
  assign done0   = w_finish & ~r_owner;
  assign done1   = w_finish & r_owner;
  // An aborted transaction reports all-ones so the requester can tell it from real data.
  assign rd_data = w_abort ? 16'hFFFF : spi_rd_data;
  assign SS0_n   = (r_state == ST_BUSY && !r_owner) ? spi_SS_n : 1'b1;
  assign SS1_n   = (r_state == ST_BUSY &&  r_owner) ? spi_SS_n : 1'b1;

endmodule

// File: tb/tb_spi_share_arb.sv
// Bench for spi_share_arb: the bench plays the SPI master and checks grants, timing and routing against a round-robin model.
module tb_spi_share_arb;

  localparam int GAP = 6;
  localparam int TMO = 4095;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] cmd0, cmd1;
  logic        done0, done1;
  logic [15:0] rd_data;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;
  logic        spi_SS_n;
  logic        SS0_n, SS1_n;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit exp_last;

  always #5 clk = ~clk;

  spi_share_arb #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
    .done0(done0), .done1(done1), .rd_data(rd_data),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done),
    .spi_rd_data(spi_rd_data), .spi_SS_n(spi_SS_n),
    .SS0_n(SS0_n), .SS1_n(SS1_n), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: a lone request wins; on a tie the one that was not served last wins.
  function automatic bit pick(input bit r0, input bit r1, input bit last);
    return (r0 && r1) ? !last : r1;
  endfunction

  task automatic idle(input int n);
    int nw = 0;
    int nd = 0;
    repeat (n) begin
      @(negedge clk);
      if (spi_wrt) nw++;
      if (done0 || done1) nd++;
    end
    check("idle_wrt", nw, 0);
    check("idle_done", nd, 0);
  endtask

  // Serves one transaction as the SPI master; returns at the negedge after the done cycle.
  task automatic run_txn(input bit own, input logic [15:0] cmd, input int exp_wait,
                         input int lat, input logic [15:0] data,
                         input bit drop_req, input bit chg_cmd, input bit peer_up);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!spi_wrt && w < 400);
    check("wrt_latency", w, exp_wait);
    check("spi_cmd", spi_cmd, cmd);
    spi_SS_n = 1'b0;
    #1;
    check("ss_owner", own ? SS1_n : SS0_n, 0);
    check("ss_other", own ? SS0_n : SS1_n, 1);
    if (drop_req) begin
      if (own) req1 = 1'b0; else req0 = 1'b0;
    end
    if (chg_cmd) begin
      if (own) cmd1 = 16'h1111; else cmd0 = 16'h1111;
    end
    if (peer_up) begin
      if (own) req0 = 1'b1; else req1 = 1'b1;
    end
    @(negedge clk);
    check("wrt_single", spi_wrt, 0);
    repeat (lat) @(negedge clk);
    check("ss_other_busy", own ? SS0_n : SS1_n, 1);
    spi_rd_data = data;
    spi_done    = 1'b1;
    #1;
    check("done_owner", {done1, done0}, own ? 2'b10 : 2'b01);
    check("rd_data", rd_data, data);
    check("cmd_held", spi_cmd, cmd);
    exp_last = own;
    @(negedge clk);
    spi_done = 1'b0;
    spi_SS_n = 1'b1;
    #1;
    check("done_clear", {done1, done0}, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit own;
    bit r0, r1;
    int w;
    logic [15:0] c;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; cmd0 = '0; cmd1 = '0;
    spi_done = 1'b0; spi_rd_data = '0; spi_SS_n = 1'b1;
    exp_last = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wrt", spi_wrt, 0);
    check("rst_cmd", spi_cmd, 16'h0000);
    check("rst_done", {done1, done0}, 0);
    check("rst_ss", {SS1_n, SS0_n}, 2'b11);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray done while idle is ignored; no request means no transaction.
    spi_done = 1'b1;
    #1;
    check("idle_spi_done", {done1, done0}, 0);
    @(negedge clk);
    spi_done = 1'b0;
    idle(10);

    // Lone requester 0; it drops its request mid-transaction and still gets done0.
    cmd0 = 16'hA200; req0 = 1'b1;
    run_txn(1'b0, 16'hA200, 1, 3, 16'h00C5, 1'b1, 1'b0, 1'b0);
    idle(GAP + 4);

    // Both requesting continuously: grants alternate, gap between transactions is GAP+2 clocks.
    cmd0 = 16'h0D02; cmd1 = 16'h2000; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      own = pick(1'b1, 1'b1, exp_last);
      run_txn(own, own ? 16'h2000 : 16'h0D02, (i == 0) ? 1 : GAP + 1,
              int'($urandom_range(1, 5)), 16'($urandom), 1'b0, 1'b0, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
    idle(GAP + 4);

    // Long requester-1 burst, requester 0 arrives mid-transaction and is served next.
    cmd1 = 16'($urandom); cmd0 = 16'h5A5A; req1 = 1'b1;
    run_txn(1'b1, cmd1, 1, 30, 16'($urandom), 1'b0, 1'b0, 1'b1);
    own = pick(1'b1, 1'b1, exp_last);
    run_txn(own, own ? cmd1 : 16'h5A5A, GAP + 1, 2, 16'($urandom), 1'b0, 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    idle(GAP + 4);

    // Command changes during BUSY do not disturb the registered command.
    cmd0 = 16'hA300; req0 = 1'b1;
    run_txn(1'b0, 16'hA300, 1, 4, 16'h1234, 1'b1, 1'b1, 1'b0);
    idle(GAP + 6);

    // Randomized request patterns against the round-robin model.
    for (int i = 0; i < 12; i++) begin
      do begin
        r0 = 1'($urandom);
        r1 = 1'($urandom);
      end while (!r0 && !r1);
      cmd0 = 16'($urandom); cmd1 = 16'($urandom);
      req0 = r0; req1 = r1;
      own = pick(r0, r1, exp_last);
      c = own ? cmd1 : cmd0;
      run_txn(own, c, 1, int'($urandom_range(1, 8)), 16'($urandom),
              1'($urandom), 1'($urandom), 1'b0);
      req0 = 1'b0; req1 = 1'b0;
      idle(GAP + 3);
    end

    // Reset mid-BUSY clears outputs asynchronously; afterwards requester 0 wins the tie.
    cmd0 = 16'hBEEF; cmd1 = 16'hCAFE; req0 = 1'b1; req1 = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!spi_wrt && w < 400);
    check("pre_rst_wrt", w, 1);
    spi_SS_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    spi_done = 1'b1;
    #1;
    check("arst_ss", {SS1_n, SS0_n}, 2'b11);
    check("arst_wrt", spi_wrt, 0);
    check("arst_done", {done1, done0}, 0);
    check("arst_cmd", spi_cmd, 16'h0000);
    spi_done = 1'b0;
    spi_SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = 1'b1;
    own = pick(1'b1, 1'b1, exp_last);
    run_txn(own, own ? 16'hCAFE : 16'hBEEF, 1, 3, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    idle(GAP + 4);

`ifdef SPI_SHARE_ARB_TMO_EN
    // Slave never answers: abort after TMO clocks, sticky err, late done ignored.
    cmd0 = 16'h7777; req0 = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!spi_wrt && w < 400);
    check("tmo_wrt", w, 1);
    spi_SS_n = 1'b0;
    spi_rd_data = 16'h0000;
    w = 0;
    while (!done0 && w < TMO + 100) begin
      @(negedge clk);
      w++;
    end
    check("tmo_cycles", w, TMO - 1);
    check("tmo_rd_data", rd_data, 16'hFFFF);
    check("tmo_done1", done1, 0);
    req0 = 1'b0;
    spi_SS_n = 1'b1;
    @(negedge clk);
    check("tmo_err", err, 1);
    spi_done = 1'b1;
    #1;
    check("late_done", {done1, done0}, 0);
    @(negedge clk);
    spi_done = 1'b0;
    idle(GAP + 4);
    cmd1 = 16'h3C3C; req1 = 1'b1;
    run_txn(1'b1, 16'h3C3C, 1, 3, 16'h4242, 1'b1, 1'b0, 1'b0);
    check("err_sticky", err, 1);
`else
    check("err_tied", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
